serial_word_receiver: RTL and testbench
=======================================

Name: serial_word_receiver

Overview:
Downstream consumer of the one-bit D flip-flop stage: samples that stage's q output as a serial line and assembles frames into parallel words.
Frame format, one bit per clock, no oversampling:
- idle high;
- start bit 0;
- W data bits, LSB first;
- stop bit 1.
Each completed word goes to the next stage through a four-phase dav_/ack_ handshake. Also reports overrun and framing errors.

Parameters:
W, 8, data bits per frame (2..16)
SYNC_STAGES, 2, synchronizer flops on serial_in (≥2); the upstream flop runs from its own clock generator

Ports:
clock  input  1  sole clock, all state updates on rising edge
reset  input  1  asynchronous, active-high
serial_in  input  1  serial line from the upstream D flip-flop q
data  output  W  received word; stable while dav_=0
dav_  output  1  data available, active low
ack_  input  1  consumer acknowledge, active low, four-phase
overrun  output  1  sticky: a valid frame was dropped because the holding register was busy
ferr  output  1  one-cycle pulse: stop bit sampled as 0

Behaviour:
- Reset (async, immediate):
  - sync chain all 1 (idle line); FSM=IDLE; bit counter 0; shift register 0;
  - data=0; dav_=1; handshake=FREE; overrun=0; ferr=0.
  - Reset mid-frame discards the partial word; no flag is raised.
- serial_s: last flop of the sync chain, i.e. serial_in delayed SYNC_STAGES edges. The FSM samples only serial_s.
- Receive FSM, 4 states:
  - IDLE: serial_s=0 → DATA, counter=0; else stay.
  - DATA: shift right with serial_s entering at bit W-1; counter+1; after the W-th bit → STOP.
  - STOP, serial_s=1, handshake FREE: data←shift register, dav_←0, handshake→HOLD; → IDLE.
  - STOP, serial_s=1, handshake not FREE: word dropped, overrun←1 (sticky until reset); → IDLE.
  - STOP, serial_s=0: ferr=1 for exactly one cycle; word dropped; → BREAK.
  - BREAK: wait for serial_s=1 → IDLE. A low line is never taken as a new start bit.
  - IDLE is entered directly from STOP, so back-to-back frames (next start bit right after the stop bit) are received with no gap.
- Latency: take the edge on which the start bit is first captured by sync flop 1 as edge 0. Then dav_ falls on edge SYNC_STAGES+W+1, which is 11 for the defaults.
- Handshake, 3 states:
  - FREE → HOLD: on word load.
  - HOLD (dav_=0): ack_=0 sampled → dav_←1, → ACKWAIT.
  - ACKWAIT: ack_=1 sampled → FREE.
  - data holds its value until the next load.
  - ack_=0 while FREE is ignored.
  - A load and ACKWAIT→FREE on the same edge: the load is refused (overrun). The handshake must be FREE at the start of the cycle for a load.
- Counter width: clog2(W+1). Counter wrap is impossible because DATA exits at W.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - FSM state encodings: IDLE, DATA, STOP, BREAK;
  - handshake encodings: FREE, HOLD, ACKWAIT;
  - constants IDLE_LEVEL=1, START_LEVEL=0.
- One sub-module is natural: bit_synchronizer, a parameterised SYNC_STAGES flop chain with async active-high reset to 1.

Test Plan:
1. Frame 0xA5: after reset, drive serial_in one bit per clock: 0, then 1,0,1,0,0,1,0,1, then 1 → dav_ falls on edge 11, data=8'hA5, overrun=0, ferr=0.
2. Handshake, with 0xA5 pending:
   - assert ack_=0 → dav_=1 on the next edge, data still 8'hA5;
   - release ack_ → handshake FREE;
   - frame 0x3C → data=8'h3C.
3. Overrun: send 0x11 then 0x22 back-to-back, never asserting ack_ → data=8'h11, dav_=0, overrun=1 on the edge of the second stop bit, and it stays 1.
4. Framing error: frame 0x55 with stop bit 0, line then held low 5 cycles, then high → ferr high exactly one cycle, dav_ stays 1, no frame detected while low. A following 0x0F frame is received correctly.
5. Reset mid-frame: assert reset after 4 data bits → data=0, dav_=1, FSM IDLE immediately with no clock edge needed. After release, 0x81 is received correctly.
6. Ack held low across a new load: 0x01 acked with ack_ held low, 0x02 sent → overrun=1, data stays 8'h01. Release ack_, send 0x03 → data=8'h03.

Source files
------------

// File: rtl/serial_word_receiver_pkg.sv
// Shared definitions for the serial word receiver.
// Holds the receive FSM and handshake encodings, plus the serial line levels.
package serial_word_receiver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    STOP  = 2'd2,
    BREAK = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    HOLD    = 2'd1,
    ACKWAIT = 2'd2
  } hs_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/serial_word_receiver_if.sv
// Parallel-side bundle of the serial word receiver.
//   data    : received word, stable while dav_ is low
//   dav_    : data available, active low
//   ack_    : consumer acknowledge, active low, four-phase
//   overrun : sticky dropped-frame flag
//   ferr    : one-cycle framing error pulse
// master = receiver (drives the word), slave = consumer (drives ack_).
interface serial_word_receiver_if #(
  parameter int W = 8
);
  logic [W-1:0] data;
  logic         dav_;
  logic         ack_;
  logic         overrun;
  logic         ferr;

  modport master (output data, dav_, overrun, ferr, input ack_);
  modport slave  (input data, dav_, overrun, ferr, output ack_);
endinterface

// File: rtl/serial_word_receiver_bit_synchronizer.sv
// Multi-flop synchronizer for one asynchronous bit.
//   clock : destination clock
//   reset : asynchronous, active-high; loads the chain with 1 (idle line)
//   d     : asynchronous input
//   q     : d delayed SYNC_STAGES rising edges
module bit_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  import serial_word_receiver_pkg::*;

  logic [SYNC_STAGES-1:0] chain;

  // chain[0] is the first (metastability-catching) flop
  always_ff @(posedge clock or posedge reset) begin
    if (reset) chain <= {SYNC_STAGES{IDLE_LEVEL}};
    else       chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/serial_word_receiver.sv
// Serial word receiver: assembles start/W data (LSB first)/stop frames into
// words and hands them over through a four-phase dav_/ack_ handshake.
//   clock     : sole clock, rising edge
//   reset     : asynchronous, active-high
//   serial_in : serial line from an upstream flop on another clock
//   bus       : master side of serial_word_receiver_if (data, dav_, ack_,
//               overrun, ferr); every output is a flop.
module serial_word_receiver #(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     serial_in,
  serial_word_receiver_if.master   bus
);
  import serial_word_receiver_pkg::*;

  localparam int CW = $clog2(W + 1);

  logic          serial_s;
  rx_state_t     rx_state, rx_next;
  hs_state_t     hs_state, hs_next;
  logic [CW-1:0] bit_cnt, bit_cnt_next;
  logic [W-1:0]  shift_q, shift_next;
  logic [W-1:0]  data_q, data_next;
  logic          dav_q, dav_next;
  logic          ovr_q, ovr_next;
  logic          ferr_q, ferr_next;
  logic          load;

  bit_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (serial_in),
    .q     (serial_s)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state <= IDLE;
      hs_state <= FREE;
      bit_cnt  <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      dav_q    <= 1'b1;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      rx_state <= rx_next;
      hs_state <= hs_next;
      bit_cnt  <= bit_cnt_next;
      shift_q  <= shift_next;
      data_q   <= data_next;
      dav_q    <= dav_next;
      ovr_q    <= ovr_next;
      ferr_q   <= ferr_next;
    end
  end

  always_comb begin
    rx_next      = rx_state;
    hs_next      = hs_state;
    bit_cnt_next = bit_cnt;
    shift_next   = shift_q;
    data_next    = data_q;
    dav_next     = dav_q;
    ovr_next     = ovr_q;
    ferr_next    = 1'b0;
    load         = 1'b0;

    case (rx_state)
      IDLE: begin
        if (serial_s == START_LEVEL) begin
          rx_next      = DATA;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        // LSB arrives first, so shifting right leaves it at bit 0 after W bits
        shift_next   = {serial_s, shift_q[W-1:1]};
        bit_cnt_next = bit_cnt + 1'b1;
        if (bit_cnt == CW'(W - 1)) rx_next = STOP;
      end
      STOP: begin
        if (serial_s == IDLE_LEVEL) begin
          // straight back to IDLE so a start bit right after the stop bit is caught
          rx_next = IDLE;
          // only a handshake already FREE this cycle may take the word
          if (hs_state == FREE) load = 1'b1;
          else                  ovr_next = 1'b1;
        end else begin
          ferr_next = 1'b1;
          rx_next   = BREAK;
        end
      end
      BREAK: begin
        // a held-low line is a break, never a fresh start bit
        if (serial_s == IDLE_LEVEL) rx_next = IDLE;
      end
      default: rx_next = IDLE;
    endcase

    case (hs_state)
      FREE: begin
        if (load) begin
          data_next = shift_q;
          dav_next  = 1'b0;
          hs_next   = HOLD;
        end
      end
      HOLD: begin
        if (!bus.ack_) begin
          dav_next = 1'b1;
          hs_next  = ACKWAIT;
        end
      end
      ACKWAIT: begin
        if (bus.ack_) hs_next = FREE;
      end
      default: hs_next = FREE;
    endcase
  end

  assign bus.data    = data_q;
  assign bus.dav_    = dav_q;
  assign bus.overrun = ovr_q;
  assign bus.ferr    = ferr_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
module tb_serial_word_receiver;
  import serial_word_receiver_pkg::*;

  localparam int W = 8;

  logic clock;
  logic reset;
  logic serial_in;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ferr_cnt;

  serial_word_receiver_if #(.W(W)) bus ();

  serial_word_receiver #(.W(W), .SYNC_STAGES(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .serial_in (serial_in),
    .bus       (bus.master)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive one bit for one clock; returns 1 time unit after the capturing edge
  task automatic send_bit(input logic b);
    serial_in = b;
    @(posedge clock);
    #1;
  endtask

  // start, W data bits LSB first, stop; line left idle-high afterwards
  task automatic send_frame(input logic [W-1:0] word, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < W; i++) send_bit(word[i]);
    send_bit(stop);
    serial_in = 1'b1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // one full four-phase acknowledge: ack_ low for one edge, then released
  task automatic ack_pulse(input string tag);
    bus.ack_ = 1'b0;
    cycles(1);
    chk({tag, "_dav_hi"}, 32'(bus.dav_), 32'd1);
    bus.ack_ = 1'b1;
    cycles(1);
  endtask

  initial begin
    reset     = 1'b1;
    serial_in = 1'b1;
    bus.ack_  = 1'b1;
    #2;
    chk("rst_data", 32'(bus.data), 32'h0);
    chk("rst_dav", 32'(bus.dav_), 32'd1);
    chk("rst_ovr", 32'(bus.overrun), 32'd0);
    chk("rst_ferr", 32'(bus.ferr), 32'd0);
    cycles(2);
    reset = 1'b0;
    cycles(3);

    // 1: frame 0xA5, dav_ falls exactly on edge 11
    send_frame(8'hA5, 1'b1);
    chk("t1_dav_e9", 32'(bus.dav_), 32'd1);
    cycles(1);
    chk("t1_dav_e10", 32'(bus.dav_), 32'd1);
    cycles(1);
    chk("t1_dav_e11", 32'(bus.dav_), 32'd0);
    chk("t1_data", 32'(bus.data), 32'hA5);
    chk("t1_ovr", 32'(bus.overrun), 32'd0);
    chk("t1_ferr", 32'(bus.ferr), 32'd0);

    // 2: handshake, then 0x3C
    bus.ack_ = 1'b0;
    cycles(1);
    chk("t2_dav_ack", 32'(bus.dav_), 32'd1);
    chk("t2_data_hold", 32'(bus.data), 32'hA5);
    bus.ack_ = 1'b1;
    cycles(1);
    chk("t2_hs_free", 32'(dut.hs_state), 32'(FREE));
    send_frame(8'h3C, 1'b1);
    cycles(2);
    chk("t2_data", 32'(bus.data), 32'h3C);
    chk("t2_dav", 32'(bus.dav_), 32'd0);
    ack_pulse("t2b");

    // 3: back-to-back 0x11, 0x22 without ack
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    cycles(1);
    chk("t3_ovr_e20", 32'(bus.overrun), 32'd0);
    cycles(1);
    chk("t3_ovr_e21", 32'(bus.overrun), 32'd1);
    chk("t3_data", 32'(bus.data), 32'h11);
    chk("t3_dav", 32'(bus.dav_), 32'd0);
    cycles(4);
    chk("t3_ovr_sticky", 32'(bus.overrun), 32'd1);
    ack_pulse("t3b");

    // 4: framing error on 0x55, line held low 5 cycles
    send_frame(8'h55, 1'b0);
    serial_in = 1'b0;
    ferr_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      ferr_cnt += int'(bus.ferr);
      chk("t4_ferr_cyc", 32'(bus.ferr), (i == 1) ? 32'd1 : 32'd0);
      chk("t4_dav_low", 32'(bus.dav_), 32'd1);
    end
    chk("t4_ferr_count", 32'(ferr_cnt), 32'd1);
    serial_in = 1'b1;
    cycles(4);
    chk("t4_dav_after", 32'(bus.dav_), 32'd1);
    chk("t4_idle", 32'(dut.rx_state), 32'(IDLE));
    send_frame(8'h0F, 1'b1);
    cycles(2);
    chk("t4_data", 32'(bus.data), 32'h0F);
    chk("t4_dav", 32'(bus.dav_), 32'd0);
    chk("t4_ferr_clr", 32'(bus.ferr), 32'd0);

    // 5: reset after 4 data bits, 0x0F still pending and overrun still set
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("t5_midframe", 32'(dut.rx_state), 32'(DATA));
    reset = 1'b1;
    #1;
    chk("t5_data", 32'(bus.data), 32'h0);
    chk("t5_dav", 32'(bus.dav_), 32'd1);
    chk("t5_ovr", 32'(bus.overrun), 32'd0);
    chk("t5_state", 32'(dut.rx_state), 32'(IDLE));
    serial_in = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(2);
    send_frame(8'h81, 1'b1);
    cycles(2);
    chk("t5_data81", 32'(bus.data), 32'h81);
    chk("t5_dav81", 32'(bus.dav_), 32'd0);
    ack_pulse("t5b");

    // 6: ack_ held low across a new word
    send_frame(8'h01, 1'b1);
    cycles(2);
    chk("t6_data01", 32'(bus.data), 32'h01);
    bus.ack_ = 1'b0;
    cycles(1);
    chk("t6_dav_ack", 32'(bus.dav_), 32'd1);
    send_frame(8'h02, 1'b1);
    cycles(2);
    chk("t6_ovr", 32'(bus.overrun), 32'd1);
    chk("t6_data_kept", 32'(bus.data), 32'h01);
    chk("t6_dav_kept", 32'(bus.dav_), 32'd1);
    bus.ack_ = 1'b1;
    cycles(1);
    send_frame(8'h03, 1'b1);
    cycles(2);
    chk("t6_data03", 32'(bus.data), 32'h03);
    chk("t6_dav03", 32'(bus.dav_), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
